// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//
// Purpose:
//   Shared types and constants for the unified memory-port arbiter.
//   - arb_state_t   : arbiter FSM states (idle, fetch granted, data granted).
//   - SEL_INSTR/DATA: encodings of the 2:1 address mux select
//                     (input 0 = fetch address, input 1 = data address).
//   - pick()        : round-robin choice between fetch and data requesters.
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    localparam logic SEL_INSTR = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

    // Returns the state that the winning requester is granted into, or IDLE
    // when nobody asks. last_served_d = 1 means data was served last, so on a
    // tie the fetch side wins.
    function automatic arb_state_t pick(input logic req_i,
                                        input logic req_d,
                                        input logic last_served_d);
        arb_state_t res;
        res = IDLE;
        if (req_i && req_d) begin
            res = last_served_d ? GNT_I : GNT_D;
        end else if (req_i) begin
            res = GNT_I;
        end else if (req_d) begin
            res = GNT_D;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose:
//   Bundles the requester handshakes and the memory-port control signals of
//   the fetch/data arbiter.
//
// Signals:
//   i_req    fetch request, held until i_ack
//   d_req    data request, held until d_ack
//   d_we     data write enable, valid while d_req = 1
//   addr_sel address mux select (0 = fetch, 1 = data)
//   mem_en   memory access active
//   mem_we   memory write strobe (data transactions only)
//   i_ack    one-cycle fetch completion pulse
//   d_ack    one-cycle data completion pulse
//   i_stall  fetch requester must wait
//   d_stall  data requester must wait
//
// Modports:
//   slave  - the arbiter side (takes requests, drives memory control/acks)
//   master - the requester/memory side
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;

    logic i_req;
    logic d_req;
    logic d_we;
    logic addr_sel;
    logic mem_en;
    logic mem_we;
    logic i_ack;
    logic d_ack;
    logic i_stall;
    logic d_stall;

    modport slave (
        input  i_req,
        input  d_req,
        input  d_we,
        output addr_sel,
        output mem_en,
        output mem_we,
        output i_ack,
        output d_ack,
        output i_stall,
        output d_stall
    );

    modport master (
        output i_req,
        output d_req,
        output d_we,
        input  addr_sel,
        input  mem_en,
        input  mem_we,
        input  i_ack,
        input  d_ack,
        input  i_stall,
        input  d_stall
    );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// -----------------------------------------------------------------------------
// lat_counter
//
// Purpose:
//   Down-counter that times out the fixed memory latency. It is loaded when a
//   grant is issued and counts down to zero, where it stops; it never wraps.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_n_i     asynchronous active-low reset (count forced to 0)
//   load_i      load load_val_i (takes priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one when the count is non-zero
//   zero_o      count equals zero
// -----------------------------------------------------------------------------
module lat_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one unified memory port between the instruction-fetch requester (I)
//   and the data-access requester (D). A grant selects the address mux input,
//   asserts mem_en (and mem_we for data writes) and holds all of it stable for
//   LAT cycles; the last cycle of a grant carries the requester's ack pulse.
//   Ties are broken round-robin. On an ack the other requester, if waiting, is
//   granted in the very next cycle; the acked requester must go back through
//   IDLE before it can win again.
//
// Parameters:
//   LAT    memory latency in cycles (1..15)
//   CNT_W  latency counter width, derived from LAT
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    mem_port_arbiter_if.slave: requests in, memory control/acks out
//
// All memory-side outputs and acks are decoded from registers only; the
// stall outputs are the only signals that combine a request input directly.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int unsigned LAT   = 3,
    localparam int unsigned CNT_W = $clog2(LAT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LAT - 1);

    arb_state_t state_q, state_d;
    arb_state_t grant;
    logic       last_q,  last_d;   // 0 = fetch served last, 1 = data
    logic       we_q,    we_d;
    logic       sel_q,   sel_d;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;

    lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk_i      (clk),
        .rst_n_i    (reset),
        .load_i     (cnt_load),
        .load_val_i (LOAD_VAL),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Next-state logic. 'grant' names the new transaction to start this edge
    // (IDLE = none); it is then applied uniformly whether it came from IDLE
    // or from a back-to-back handover in an ack cycle.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        we_d     = we_q;
        sel_d    = sel_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        grant    = IDLE;

        case (state_q)
            IDLE: begin
                grant = pick(bus.i_req, bus.d_req, last_q);
            end
            GNT_I: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    last_d  = 1'b0;
                    state_d = IDLE;
                    // Fetch just finished: only data may follow directly.
                    grant   = pick(1'b0, bus.d_req, 1'b0);
                end
            end
            GNT_D: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    last_d  = 1'b1;
                    state_d = IDLE;
                    // Data just finished: only fetch may follow directly.
                    grant   = pick(bus.i_req, 1'b0, 1'b1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant == GNT_I) begin
            state_d  = GNT_I;
            sel_d    = SEL_INSTR;
            cnt_load = 1'b1;
        end else if (grant == GNT_D) begin
            state_d  = GNT_D;
            sel_d    = SEL_DATA;
            we_d     = bus.d_we;   // latched once; later d_we changes ignored
            cnt_load = 1'b1;
        end
    end

    // last_q resets to "data served last" so fetch wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            sel_q   <= SEL_INSTR;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.mem_en   = (state_q != IDLE);
    assign bus.addr_sel = sel_q;
    assign bus.mem_we   = (state_q == GNT_D) & we_q;
    assign bus.i_ack    = (state_q == GNT_I) & cnt_zero;
    assign bus.d_ack    = (state_q == GNT_D) & cnt_zero;
    assign bus.i_stall  = bus.i_req & ~bus.i_ack;
    assign bus.d_stall  = bus.d_req & ~bus.d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiter instances share clk/reset: u_dut3 (LAT=3) and u_dut1 (LAT=1).
// Each scenario row is {i_req, d_req, d_we, expected outputs}, where the
// expected outputs are {mem_en, addr_sel, mem_we, i_ack, d_ack, i_stall,
// d_stall} for the cycle in which those inputs are applied. Inputs are driven
// 1 time unit after a rising edge, the expected vector is queued, and the
// outputs are sampled on the following falling edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic clk;
    logic reset;

    int errors;
    int checks;

    logic [6:0] exp_q[$];

    mem_port_arbiter_if b3 ();
    mem_port_arbiter_if b1 ();

    mem_port_arbiter #(.LAT(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3)
    );

    mem_port_arbiter #(.LAT(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] snap3();
        return {b3.mem_en, b3.addr_sel, b3.mem_we, b3.i_ack, b3.d_ack,
                b3.i_stall, b3.d_stall};
    endfunction

    function automatic logic [6:0] snap1();
        return {b1.mem_en, b1.addr_sel, b1.mem_we, b1.i_ack, b1.d_ack,
                b1.i_stall, b1.d_stall};
    endfunction

    // Applies one row's inputs to the chosen instance and queues its
    // expected outputs.
    task automatic drive(input bit lat1, input logic [9:0] row);
        if (lat1) begin
            b1.i_req = row[9];
            b1.d_req = row[8];
            b1.d_we  = row[7];
        end else begin
            b3.i_req = row[9];
            b3.d_req = row[8];
            b3.d_we  = row[7];
        end
        exp_q.push_back(row[6:0]);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        b3.i_req = 1'b0; b3.d_req = 1'b0; b3.d_we = 1'b0;
        b1.i_req = 1'b0; b1.d_req = 1'b0; b1.d_we = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        logic [6:0] e;
        #2;
        checks++;
        if (snap3() !== 7'b0) begin
            errors++;
            $display("FAIL reset_lat3: got %b expected %b", snap3(), 7'b0);
        end
        checks++;
        if (snap1() !== 7'b0) begin
            errors++;
            $display("FAIL reset_lat1: got %b expected %b", snap1(), 7'b0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (snap3() !== 7'b0) begin
            errors++;
            $display("FAIL reset_held: got %b expected %b", snap3(), 7'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 10'b000_0000000);
            @(negedge clk);
            got = snap3();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_idle c%0d: got %b expected %b", c, got, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_lone_fetch();
        logic [9:0] tbl [6] = '{
            10'b100_0000010, 10'b100_1000010, 10'b100_1000010,
            10'b100_1001000, 10'b000_0000000, 10'b000_0000000};
        logic [6:0] got;
        logic [6:0] e;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, tbl[c]);
            @(negedge clk);
            got = snap3();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL lone_fetch c%0d: got %b expected %b", c, got, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // d_we drops in cycle 2 while the write is in flight; mem_we must hold.
    task automatic test_lone_write();
        logic [9:0] tbl [6] = '{
            10'b011_0000001, 10'b011_1110001, 10'b010_1110001,
            10'b011_1110100, 10'b000_0100000, 10'b000_0100000};
        logic [6:0] got;
        logic [6:0] e;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, tbl[c]);
            @(negedge clk);
            got = snap3();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL lone_write c%0d: got %b expected %b", c, got, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // From reset: I wins the tie, D follows with no bubble, I returns via IDLE.
    task automatic test_simultaneous();
        logic [9:0] tbl [12] = '{
            10'b110_0000011, 10'b110_1000011, 10'b110_1000011,
            10'b110_1001001, 10'b010_1100001, 10'b010_1100001,
            10'b010_1100100, 10'b100_0100010, 10'b100_1000010,
            10'b100_1000010, 10'b100_1001000, 10'b000_0000000};
        logic [6:0] got;
        logic [6:0] e;
        pulse_reset();
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, tbl[c]);
            @(negedge clk);
            got = snap3();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL simultaneous c%0d: got %b expected %b", c, got, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // I was served last, so D wins the tie; I then follows back-to-back.
    task automatic test_back_to_back();
        logic [9:0] tbl [8] = '{
            10'b111_0000011, 10'b111_1110011, 10'b111_1110011,
            10'b111_1110110, 10'b100_1000010, 10'b100_1000010,
            10'b100_1001000, 10'b000_0000000};
        logic [6:0] got;
        logic [6:0] e;
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, tbl[c]);
            @(negedge clk);
            got = snap3();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL back_to_back c%0d: got %b expected %b", c, got, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Reset lands while the data grant has one count left; no ack may follow.
    task automatic test_mid_reset();
        logic [9:0] tbl [3] = '{
            10'b011_0000001, 10'b011_1110001, 10'b011_1110001};
        logic [6:0] got;
        logic [6:0] e;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, tbl[c]);
            @(negedge clk);
            got = snap3();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL mid_reset_pre c%0d: got %b expected %b", c, got, e);
            end
            if (c < 2) begin
                @(posedge clk);
                #1;
            end
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (snap3() !== 7'b0000001) begin
            errors++;
            $display("FAIL mid_reset_async: got %b expected %b", snap3(), 7'b0000001);
        end
        b3.d_req = 1'b0;
        b3.d_we  = 1'b0;
        #1;
        checks++;
        if (snap3() !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset_drop: got %b expected %b", snap3(), 7'b0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (snap3() !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset_held: got %b expected %b", snap3(), 7'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 10'b000_0000000);
            @(negedge clk);
            got = snap3();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL mid_reset_post c%0d: got %b expected %b", c, got, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // LAT=1: with both requests held the grant alternates every cycle, each
    // grant cycle carrying exactly one ack.
    task automatic test_lat1_alternate();
        logic [9:0] tbl [10] = '{
            10'b111_0000011, 10'b111_1001001, 10'b111_1110110,
            10'b111_1001001, 10'b111_1110110, 10'b111_1001001,
            10'b111_1110110, 10'b111_1001001, 10'b000_1110100,
            10'b000_0100000};
        logic [6:0] got;
        logic [6:0] e;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, tbl[c]);
            @(negedge clk);
            got = snap1();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL lat1_alternate c%0d: got %b expected %b", c, got, e);
            end
            checks++;
            if ((b1.i_ack & b1.d_ack) !== 1'b0) begin
                errors++;
                $display("FAIL lat1_dual_ack c%0d: got i_ack=%b d_ack=%b expected not both",
                         c, b1.i_ack, b1.d_ack);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        b3.i_req = 1'b0; b3.d_req = 1'b0; b3.d_we = 1'b0;
        b1.i_req = 1'b0; b1.d_req = 1'b0; b1.d_we = 1'b0;

        test_reset();
        test_lone_fetch();
        test_lone_write();
        test_simultaneous();
        test_back_to_back();
        test_mid_reset();
        test_lat1_alternate();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch requester (I) and the data-access requester (D).
- Drives the select of the 64-bit 2:1 address mux: i0 = fetch address, i1 = data address.
- Also drives memory enable and write-enable, and produces per-requester ack and stall.
- Memory has fixed latency LAT. The arbiter counts it out and holds the mux select stable for the whole transaction.

Parameters:
- LAT, 3, memory access latency in cycles, legal range 1..15.
- CNT_W, $clog2(LAT+1), width of the latency counter; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- i_req  input  1  instruction fetch request; held high until i_ack.
- d_req  input  1  data access request; held high until d_ack.
- d_we  input  1  data write enable, valid while d_req=1.
- addr_sel  output  1  address mux select; 0 = instruction, 1 = data.
- mem_en  output  1  memory access active.
- mem_we  output  1  memory write strobe; data transactions only.
- i_ack  output  1  one-cycle pulse: fetch transaction complete.
- d_ack  output  1  one-cycle pulse: data transaction complete.
- i_stall  output  1  i_req & ~i_ack.
- d_stall  output  1  d_req & ~d_ack.

Behaviour:
- States: IDLE, GNT_I, GNT_D. Registers: state, cnt[CNT_W-1:0], last (0 = I served last, 1 = D), we_q, sel_q.
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, last=1 so I wins the first tie.
  - we_q=0, sel_q=0.
  - Outputs: addr_sel=0, mem_en=0, mem_we=0, i_ack=0, d_ack=0.
- Outputs decode from registers only; no combinational path from req to mem_en/addr_sel/ack:
  - mem_en = (state != IDLE).
  - addr_sel = sel_q.
  - mem_we = (state == GNT_D) & we_q.
  - i_ack = (state == GNT_I) & (cnt == 0).
  - d_ack = (state == GNT_D) & (cnt == 0).
- Arbitration function pick(reqI, reqD):
  - only I requests → I; only D requests → D.
  - both request → the requester that is not `last` (round-robin).
  - neither requests → none.
- IDLE: evaluate pick(i_req, d_req).
  - I → next state GNT_I, cnt=LAT-1, sel_q=0.
  - D → next state GNT_D, cnt=LAT-1, sel_q=1, we_q=d_we.
  - none → stay IDLE; sel_q holds its value.
- GNT_x with cnt != 0: cnt decrements by 1. Inputs are ignored, including a d_we change.
- GNT_x with cnt == 0 (ack cycle):
  - last := x.
  - Next grant = pick() with the acked requester's req forced to 0. The other requester, if requesting, is granted back-to-back with no IDLE bubble. Otherwise go to IDLE.
  - The same requester is never re-granted back-to-back. It re-arbitrates from IDLE.
- Latency:
  - Request seen in IDLE at edge T → mem_en=1 in cycle T+1 → ack in cycle T+LAT.
  - LAT=1 → ack in the first grant cycle.
- Request dropped mid-transaction: the transaction still completes and ack still pulses; the requester ignores it. No abort.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at reset values. No ack is issued.
- cnt never wraps; it is loaded only on grant.

Decomposition:
- Package mem_arb_pkg:
  - enum arb_state_t {IDLE, GNT_I, GNT_D}.
  - constants SEL_INSTR=1'b0, SEL_DATA=1'b1.
- Sub-module lat_counter #(CNT_W): load/decrement down-counter with a zero flag and asynchronous active-low reset. The arbiter FSM stays in mem_port_arbiter.

Test Plan:
- Reset check (LAT=3): reset=0 → all outputs 0, addr_sel=0. Release reset with i_req=d_req=0 → mem_en stays 0.
- Lone fetch: i_req=1 at edge 0.
  - mem_en=1, addr_sel=0 on cycles 1–3.
  - i_ack=1 only in cycle 3; i_stall=1 in cycles 0–2.
  - Returns to IDLE in cycle 4.
- Lone data write: d_req=1, d_we=1.
  - addr_sel=1, mem_we=1 for 3 cycles, then d_ack.
  - Toggling d_we in cycle 2 leaves mem_we=1.
- Simultaneous requests from reset: i_req=d_req=1 held.
  - I granted cycles 1–3, D granted cycles 4–6 with no bubble, addr_sel 0→1 at cycle 4.
  - Then I again via IDLE at cycle 8.
- Mid-transaction reset: during GNT_D cnt=1, pulse reset=0 → mem_en, addr_sel, d_ack=0 asynchronously; state IDLE. No d_ack is ever seen for that transaction.
- LAT=1 build: i_req, d_req alternating each cycle → ack in every grant cycle; addr_sel follows grants; never two acks in one cycle.
